// File: rtl/trail_stack.sv
// Assignment trail for the DPLL core: push/pop/replace of decided and forced assignments,
// plus a one-entry-per-cycle backtrack unwind. Optional high-water mark under TRAIL_HWM_EN.
module trail_stack #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned VAR_BITS = 6,
  parameter int unsigned LVL_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic                type_in,
  input  logic                val_in,
  input  logic [VAR_BITS-1:0] var_in,
  input  logic                bt_start,
`ifdef TRAIL_HWM_EN
  input  logic                hwm_clr,
  output logic [LVL_BITS-1:0] hwm,
`endif
  output logic                top_type,
  output logic                top_val,
  output logic [VAR_BITS-1:0] top_var,
  output logic                out_valid,
  output logic                out_type,
  output logic                out_val,
  output logic [VAR_BITS-1:0] out_var,
  output logic                bt_done,
  output logic                bt_unsat,
  output logic                busy,
  output logic                empty,
  output logic                full,
  output logic [LVL_BITS-1:0] count,
  output logic [LVL_BITS-1:0] level,
  output logic                overflow
);

  localparam int unsigned IdxBits = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_BITS-1:0] CntOne = LVL_BITS'(1);
  localparam logic [LVL_BITS-1:0] CntMax = LVL_BITS'(DEPTH);

  typedef enum logic [0:0] {StIdle, StUnwind} state_e;

  state_e              state_q, state_d;
  logic [LVL_BITS-1:0] count_q, count_d;
  logic [LVL_BITS-1:0] level_q, level_d;
  logic                overflow_q, overflow_d;

  // Entry layout: {type, val, var}
  logic [VAR_BITS+1:0] mem_q [DEPTH];
  logic                wr_en;
  logic [IdxBits-1:0]  wr_idx;
  logic [VAR_BITS+1:0] wr_data;
  logic [IdxBits-1:0]  top_idx;
  logic [IdxBits-1:0]  push_idx;
  logic [VAR_BITS+1:0] top_entry;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntMax);
  assign busy     = (state_q == StUnwind);
  assign count    = count_q;
  assign level    = level_q;
  assign overflow = overflow_q;

  assign top_idx   = IdxBits'(count_q - CntOne);
  assign push_idx  = IdxBits'(count_q);
  assign top_entry = empty ? '0 : mem_q[top_idx];
  assign top_type  = top_entry[VAR_BITS+1];
  assign top_val   = top_entry[VAR_BITS];
  assign top_var   = top_entry[VAR_BITS-1:0];
  assign wr_data   = {type_in, val_in, var_in};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    out_valid  = 1'b0;
    out_type   = 1'b0;
    out_val    = 1'b0;
    out_var    = '0;
    bt_done    = 1'b0;
    bt_unsat   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bt_start) begin
          if (empty) begin
            bt_done  = 1'b1;
            bt_unsat = 1'b1;
          end else begin
            state_d = StUnwind;
          end
        end else if (push && pop && !empty) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
          // New decision over old forced raises level; the reverse lowers it; else unchanged.
          if (!type_in && top_type) begin
            level_d = level_q + CntOne;
          end else if (type_in && !top_type) begin
            level_d = level_q - CntOne;
          end
        end else if (push) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CntOne;
            if (!type_in) begin
              level_d = level_q + CntOne;
            end
          end
        end else if (pop && !empty) begin
          count_d = count_q - CntOne;
          if (!top_type && (level_q != '0)) begin
            level_d = level_q - CntOne;
          end
        end
      end
      StUnwind: begin
        out_valid = 1'b1;
        out_type  = top_type;
        out_val   = top_val;
        out_var   = top_var;
        count_d   = count_q - CntOne;
        if (!top_type) begin
          if (level_q != '0) begin
            level_d = level_q - CntOne;
          end
          bt_done = 1'b1;
          state_d = StIdle;
        end else if (count_q == CntOne) begin
          bt_done  = 1'b1;
          bt_unsat = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

`ifdef TRAIL_HWM_EN
  logic [LVL_BITS-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = count_q;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_trail_stack.sv
// Directed bench for trail_stack (DEPTH=4): queue-based reference model checked every
// negedge, plus literal expectations from the test plan.
module tb_trail_stack;

  localparam int unsigned Depth = 4;
  localparam int unsigned VarBits = 6;
  localparam int unsigned LvlBits = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic push, pop, type_in, val_in, bt_start;
  logic [VarBits-1:0] var_in;
  logic top_type, top_val, out_valid, out_type, out_val, bt_done, bt_unsat;
  logic busy, empty, full, overflow;
  logic [VarBits-1:0] top_var, out_var;
  logic [LvlBits-1:0] count, level;
`ifdef TRAIL_HWM_EN
  logic hwm_clr;
  logic [LvlBits-1:0] hwm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  trail_stack #(
    .DEPTH   (Depth),
    .VAR_BITS(VarBits),
    .LVL_BITS(LvlBits)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .type_in  (type_in),
    .val_in   (val_in),
    .var_in   (var_in),
    .bt_start (bt_start),
`ifdef TRAIL_HWM_EN
    .hwm_clr  (hwm_clr),
    .hwm      (hwm),
`endif
    .top_type (top_type),
    .top_val  (top_val),
    .top_var  (top_var),
    .out_valid(out_valid),
    .out_type (out_type),
    .out_val  (out_val),
    .out_var  (out_var),
    .bt_done  (bt_done),
    .bt_unsat (bt_unsat),
    .busy     (busy),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .level    (level),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the trail as a queue of {type, val, var}.
  typedef struct packed {logic typ; logic val; logic [VarBits-1:0] vr;} ent_t;
  ent_t q[$];
  bit   m_busy = 0;
  bit   m_ovf = 0;
  bit   rst_seen = 0;

  initial forever begin
    @(negedge reset_n);
    rst_seen = 1;
  end

  initial forever begin
    ent_t t;
    int   lvl;
    bit   e_done, e_unsat;
    @(negedge clock);
    if (!reset_n || rst_seen) begin
      q.delete();
      m_busy   = 0;
      m_ovf    = 0;
      rst_seen = 0;
    end
    t = (q.size() > 0) ? q[q.size()-1] : '0;
    lvl = 0;
    foreach (q[i]) if (!q[i].typ) lvl++;
    if (m_busy) begin
      e_done  = !t.typ || (q.size() == 1);
      e_unsat = t.typ && (q.size() == 1);
    end else begin
      e_done  = bt_start && (q.size() == 0);
      e_unsat = e_done;
    end
    chk("m_count", count, q.size());
    chk("m_level", level, lvl);
    chk("m_empty", empty, q.size() == 0);
    chk("m_full", full, q.size() == Depth);
    chk("m_overflow", overflow, m_ovf);
    chk("m_busy", busy, m_busy);
    chk("m_top", {top_type, top_val, top_var}, t);
    chk("m_out_valid", out_valid, m_busy);
    chk("m_out", {out_type, out_val, out_var}, m_busy ? t : '0);
    chk("m_bt_done", bt_done, e_done);
    chk("m_bt_unsat", bt_unsat, e_unsat);
    if (reset_n) begin
      if (m_busy) begin
        void'(q.pop_back());
        if (e_done) m_busy = 0;
      end else if (bt_start) begin
        if (q.size() > 0) m_busy = 1;
      end else if (push && pop && q.size() > 0) begin
        q[q.size()-1] = {type_in, val_in, var_in};
      end else if (push) begin
        if (q.size() == Depth) m_ovf = 1;
        else q.push_back({type_in, val_in, var_in});
      end else if (pop && q.size() > 0) begin
        void'(q.pop_back());
      end
    end
  end

  task automatic idle_in();
    push = 0; pop = 0; type_in = 0; val_in = 0; var_in = '0; bt_start = 0;
  endtask

  // Apply one command for one clock edge, leaving inputs idle at posedge+1.
  task automatic drive(input logic p, input logic po, input logic t, input logic v,
                       input logic [VarBits-1:0] vr, input logic bs);
    push = p; pop = po; type_in = t; val_in = v; var_in = vr; bt_start = bs;
    @(posedge clock);
    #1;
    idle_in();
  endtask

  logic [VarBits-1:0] exp_vars [3] = '{6'd7, 6'd5, 6'd3};

  initial begin
    idle_in();
`ifdef TRAIL_HWM_EN
    hwm_clr = 0;
`endif
    reset_n = 1;
    #1 reset_n = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
    @(posedge clock); #1;

    // D(v3=1), F(v5=0), F(v7=1)
    drive(1, 0, 0, 1, 6'd3, 0);
    drive(1, 0, 1, 0, 6'd5, 0);
    drive(1, 0, 1, 1, 6'd7, 0);
    @(negedge clock);
    chk("push3_count", count, 3);
    chk("push3_level", level, 1);
    chk("push3_top", {top_type, top_val, top_var}, {2'b11, 6'd7});
    @(posedge clock); #1;

    drive(0, 0, 0, 0, '0, 1);
    // Commands while busy must be ignored.
    push = 1; pop = 1; bt_start = 1; var_in = 6'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bt_valid", out_valid, 1);
      chk("bt_var", out_var, exp_vars[i]);
      chk("bt_done_at", bt_done, i == 2);
      if (i == 2) chk("bt_last", {out_type, out_val, bt_unsat}, 3'b010);
      @(posedge clock); #1;
    end
    idle_in();
    @(negedge clock);
    chk("bt_end", {count, level, busy}, 7'd0);
    @(posedge clock); #1;

    // Unwind with no decision left.
    drive(1, 0, 1, 0, 6'd1, 0);
    drive(0, 0, 0, 0, '0, 1);
    @(negedge clock);
    chk("unsat_out", {out_valid, out_var, bt_done, bt_unsat}, {1'b1, 6'd1, 2'b11});
    @(posedge clock); #1;
    bt_start = 1;
    @(negedge clock);
    chk("empty_bt", {count, bt_done, bt_unsat, busy}, {3'd0, 3'b110});
    @(posedge clock); #1;
    idle_in();

    // Fill with decisions v0..v3 (val 0), then overflow.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 6'(i), 0);
    @(negedge clock);
    chk("fill_full", {full, level}, {1'b1, 3'd4});
    @(posedge clock); #1;
    drive(1, 0, 1, 1, 6'd40, 0);
    @(negedge clock);
    chk("ovf_set", {count, overflow}, {3'd4, 1'b1});
    @(posedge clock); #1;
    drive(0, 1, 0, 0, '0, 0);
    @(negedge clock);
    chk("ovf_sticky", {count, level, overflow}, {3'd3, 3'd3, 1'b1});
    chk("top_d2", {top_type, top_val, top_var}, {2'b00, 6'd2});
    @(posedge clock); #1;

    // Replace D(v2=0) with F(v2=1).
    drive(1, 1, 1, 1, 6'd2, 0);
    @(negedge clock);
    chk("repl", {count, level}, {3'd3, 3'd2});
    chk("repl_top", {top_type, top_val, top_var}, {2'b11, 6'd2});
    @(posedge clock); #1;

    // Abort an unwind with reset.
    drive(0, 0, 0, 0, '0, 1);
    @(negedge clock);
    chk("abort_busy", busy, 1);
    #2 reset_n = 0;
    #1;
    chk("abort", {busy, count, out_valid, bt_done, overflow}, 7'd0);
    @(posedge clock); #1 reset_n = 1;

`ifdef TRAIL_HWM_EN
    chk("hwm_rst", hwm, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 6'(i), 0);
    drive(0, 1, 0, 0, '0, 0);
    drive(0, 1, 0, 0, '0, 0);
    @(negedge clock);
    chk("hwm_max", hwm, 3);
    @(posedge clock); #1;
    hwm_clr = 1;
    @(posedge clock); #1;
    hwm_clr = 0;
    @(negedge clock);
    chk("hwm_clr", hwm, 1);
`endif

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/trail_stack.md
# trail_stack

Parametrised assignment trail for the DPLL core. It records decided and forced (implied) variable assignments in push order and supports single pops and top replacement. It also runs a hardware backtrack that unwinds the trail, one entry per cycle, down to and including the most recent decision. It sits between the decide/BCP units and the variable-assignment table: the table clears each streamed entry, and the decide unit receives the flipped decision.

## Interface
Parameters:
- DEPTH, 64: maximum number of trail entries.
- VAR_BITS, 6: variable index width.
- LVL_BITS, $clog2(DEPTH+1): width of the decision-level and pointer counters.

Ports:
- clock  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- push  in  1: push {type_in, val_in, var_in}.
- pop  in  1: pop the top entry.
- type_in  in  1: 0 = decision, 1 = forced.
- val_in  in  1: assigned value.
- var_in  in  VAR_BITS: variable index.
- bt_start  in  1: start a backtrack.
- top_type, top_val  out  1: top entry fields; 0 when empty.
- top_var  out  VAR_BITS: top entry variable; 0 when empty.
- out_valid  out  1: an entry is being unwound this cycle.
- out_type, out_val  out  1: fields of the unwound entry; 0 when !out_valid.
- out_var  out  VAR_BITS: variable of the unwound entry; 0 when !out_valid.
- bt_done  out  1: backtrack finished this cycle.
- bt_unsat  out  1: qualifies bt_done; no decision was left on the trail.
- busy  out  1: unwind in progress.
- empty, full  out  1: occupancy flags.
- count  out  LVL_BITS: number of entries on the trail.
- level  out  LVL_BITS: number of decision entries on the trail.
- overflow  out  1: sticky; set by a push attempted while full.

## Operation
- Reset values: count=0, level=0, empty=1, full=0, overflow=0, state=IDLE. All other outputs are 0. Storage is not reset.
- empty = (count==0). full = (count==DEPTH).
- top_* always shows entry[count-1] (show-ahead), combinationally.
- FSM has two states, IDLE and UNWIND. busy = (state==UNWIND).
- IDLE command priority: bt_start, then push&&pop, then push, then pop.
  - bt_start with empty: bt_done=1 and bt_unsat=1 combinationally in the same cycle. State stays IDLE.
  - bt_start with !empty: go to UNWIND. No pop happens in this cycle.
  - push&&pop with !empty: overwrite entry[count-1]; count unchanged. level changes by +1 if type_in==0, and by -1 if the old top type==0 (both can apply).
  - push&&pop with empty: treated as a plain push.
  - push with !full: write entry[count], count+1. level+1 if type_in==0.
  - push with full: write dropped, overflow<=1, nothing else changes.
  - pop with !empty: count-1. level-1 if top_type==0. Pop with empty is ignored.
- UNWIND, every cycle:
  - out_valid=1 and out_*=top_*; count-1.
  - If out_type==0: level-1, bt_done=1, go to IDLE. The decide unit flips the decision using out_var and ~out_val.
  - Else if count==1: bt_done=1, bt_unsat=1, go to IDLE.
- push, pop and bt_start are ignored while busy.
- Arithmetic: count and level never wrap. level<=count always holds.

## Timing
- State, count, level and flags update on the rising clock edge. top_*, out_*, bt_done and bt_unsat are combinational from registered state.
- A backtrack over k entries (the last one a decision) takes k UNWIND cycles after the bt_start cycle. bt_done coincides with the final out_valid.
- The first accepted command is in the cycle after bt_done.
- Asserting reset_n low mid-unwind aborts immediately: state=IDLE, count=0, no bt_done.
- Pushed data is visible on top_* in the cycle after the push.

## Configuration
- TRAIL_HWM_EN defined:
  - Adds output hwm (LVL_BITS), the maximum count since reset. Reset value 0; updated on the edge where count exceeds it.
  - Adds input hwm_clr (1 bit), which sets hwm to the current count on the next edge.
- TRAIL_HWM_EN undefined: neither port exists and there is no register. All other behaviour is identical.

## Test plan
- Reset, then push D(v3=1), F(v5=0), F(v7=1) -> count=3, level=1, top = {1,1,7}.
- From that state, pulse bt_start -> three out_valid cycles with var 7, 5, 3. bt_done is asserted on var 3 with out_val=1 and out_type=0. Then count=0, level=0, busy=0.
- Push F(v1=0) only, then bt_start -> one out_valid cycle (var 1) with bt_done=1 and bt_unsat=1. count=0.
- Fill DEPTH=4 with decisions -> full=1, level=4. A fifth push leaves count=4 and sets overflow=1; overflow stays 1 after a subsequent pop.
- With top D(v2=0), push&&pop with F(v2=1) -> count unchanged, level-1, top = {1,1,2}. push, pop and bt_start during UNWIND are ignored.
- With TRAIL_HWM_EN defined: push 3, pop 2 -> hwm=3. Then hwm_clr -> hwm=1. Assert reset_n low mid-unwind -> all outputs at reset values.
